zero_strip: RTL and testbench
=============================

Name: zero_strip

Overview:
- Receive-side counterpart of the fixed-length zero padder: turns fixed-length padded AXI-Stream packets back into payload-length packets.
- Forwards the first len beats of each input packet, asserts o_tlast on the last kept beat, and silently consumes the remaining (padding) beats up to the input i_tlast.
- Sits in the RFNoC datapath after the zero-padded processing stage (e.g. after FFT/filter blocks), with one registered output stage.

Parameters:
- WIDTH, 32, sample/data width in bits.
- MAX_LEN, 4096, largest supported payload length in beats; sets the width of len: LW = $clog2(MAX_LEN+1).

Ports:
- clk  input  1  block clock.
- reset_n  input  1  asynchronous, active-low reset.
- len  input  LW  payload length to keep; sampled on the first beat of each packet.
- i_tdata  input  WIDTH  padded input sample.
- i_tlast  input  1  end of padded input packet.
- i_tvalid  input  1  input valid.
- i_tready  output  1  input ready.
- o_tdata  output  WIDTH  stripped output sample.
- o_tlast  output  1  end of stripped output packet.
- o_tvalid  output  1  output valid.
- o_tready  input  1  downstream ready.
- o_short  output  1  one-cycle pulse: an input packet ended before len beats were kept.

Behaviour:
- Reset (asynchronous, reset_n=0): o_tvalid=0, o_tlast=0, o_tdata=0, o_short=0, state=PASS, cnt=0, first=1. Reset asserted mid-packet aborts immediately. The held output beat is lost and o_tvalid drops without waiting for o_tready.
- Output register: single stage. Latency is 1 cycle from input handshake to o_tvalid.
  - Output register is loaded when i_tvalid & i_tready in PASS.
  - o_tvalid clears on o_tready when no new beat is loaded in the same cycle.
  - Registered outputs are held stable while o_tvalid & ~o_tready.
- Handshake:
  - PASS: i_tready = ~o_tvalid | o_tready.
  - DROP: i_tready = 1 regardless of downstream; dropped beats never reach the output.
- Length latch:
  - On an accepted beat with first=1, len_r <= len (the comparison for that same beat uses len directly), then first <= 0.
  - first <= 1 after any accepted beat with i_tlast=1.
  - len changes mid-packet are ignored.
- len_r=0 is bypass: every beat is forwarded with o_tlast = i_tlast, cnt is unused, and o_short never fires.
- State PASS, per accepted beat (k = cnt):
  - i_tlast=1: forward the beat with o_tlast=1; cnt<=0; stay PASS. If k+1 < len_r (nonzero), pulse o_short.
  - i_tlast=0 and k == len_r-1: forward with o_tlast=1; cnt<=0; go to DROP.
  - Otherwise: forward with o_tlast=0; cnt<=cnt+1.
- State DROP, per accepted beat: discard it. If i_tlast=1: go to PASS, first<=1.
- Exact fit (input packet length == len_r; the last kept beat also has i_tlast=1): o_tlast=1 once, stay PASS, no DROP cycle, no o_short.
- cnt is LW bits wide. A packet longer than MAX_LEN with len=0 (bypass) must not wrap into a false tlast.
- o_short is registered: it pulses in the same cycle the short beat appears on o_tvalid, for exactly one clk.
- Backpressure in PASS stalls the input. A packet's padding tail is drained at 1 beat/cycle even while the output is stalled on a held beat.

Test Plan:
- len=4; 8-beat packet 0x10..0x17, tlast on 0x17; o_tready=1 -> output 0x10..0x13, tlast on 0x13. 0x14..0x17 consumed with i_tready=1. Output beats lag input by 1 cycle.
- len=4; 3-beat packet 0xA0..0xA2, tlast on 0xA2 -> output 3 beats, tlast on 0xA2, o_short pulses once, with 0xA2 valid.
- len=4; two back-to-back 4-beat packets (exact fit) -> 8 output beats, tlast on beats 4 and 8, no DROP cycles, no gaps, o_short=0.
- len=2 then len changed to 5 during the padding of packet 1 (6 beats); packet 2 is 6 beats -> packet 1 outputs 2 beats; packet 2 outputs 5 beats, tlast on the 5th; 6th dropped.
- len=3; random o_tready (~50%) over 20 packets of 6 beats with counting data -> output sequence matches 0,1,2 | 6,7,8 | ..., with no data change while o_tvalid & ~o_tready.
- len=0; 5-beat packet -> passed unchanged, tlast on beat 5. Then assert reset_n=0 mid-packet with a beat held -> o_tvalid=0 immediately. The next packet after release starts at cnt=0.

Source files
------------

// File: rtl/zero_strip.sv
// zero_strip: turns fixed-length zero-padded AXI-Stream packets back into payload-length
// packets by keeping the first len beats of each packet and draining the padding tail.
`default_nettype none

module zero_strip #(
    parameter int WIDTH   = 32,
    parameter int MAX_LEN = 4096,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [LW-1:0]    len,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             o_short
);

    localparam logic [0:0] S_PASS = 1'b0;
    localparam logic [0:0] S_DROP = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [LW-1:0] cnt;
    logic [LW-1:0] len_r;
    logic          first;

    logic [LW-1:0] eff_len;
    logic          bypass;
    logic [LW:0]   cnt_inc;
    logic          last_kept;
    logic          short_beat;
    logic          accept;
    logic          load;

    // The first beat of a packet compares against the live len, later beats against the latch.
    assign eff_len    = first ? len : len_r;
    assign bypass     = (eff_len == '0);
    assign cnt_inc    = {1'b0, cnt} + {{LW{1'b0}}, 1'b1};
    assign last_kept  = (cnt_inc == {1'b0, eff_len});
    assign short_beat = i_tlast & ~bypass & (cnt_inc < {1'b0, eff_len});
    assign accept     = i_tvalid & i_tready;
    assign load       = accept & (state == S_PASS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_PASS;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_PASS: begin
                if (load && !bypass && !i_tlast && last_kept) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (accept && i_tlast) begin
                    state_next = S_PASS;
                end
            end
            default: state_next = S_PASS;
        endcase
    end

    // Padding is drained regardless of a stalled output beat.
    always_comb begin
        i_tready = 1'b1;
        if (state == S_PASS) begin
            i_tready = ~o_tvalid | o_tready;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            o_tvalid <= 1'b0;
            o_short  <= 1'b0;
            cnt      <= '0;
        end else if (load) begin
            o_tdata  <= i_tdata;
            o_tlast  <= bypass ? i_tlast : (i_tlast | last_kept);
            o_tvalid <= 1'b1;
            o_short  <= short_beat;
            cnt      <= (bypass || i_tlast || last_kept) ? '0 : cnt_inc[LW-1:0];
        end else begin
            o_short <= 1'b0;
            if (o_tready) begin
                o_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first <= 1'b1;
            len_r <= '0;
        end else if (accept) begin
            if (first) begin
                len_r <= len;
            end
            first <= i_tlast;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_zero_strip.sv
// tb_zero_strip: directed self-checking bench for zero_strip.
`default_nettype none

module tb_zero_strip;
    localparam int WIDTH   = 32;
    localparam int MAX_LEN = 4096;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [LW-1:0]    len = '0;
    logic [WIDTH-1:0] i_tdata = '0;
    logic             i_tlast = 1'b0;
    logic             i_tvalid = 1'b0;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready = 1'b1;
    logic             o_short;

    zero_strip #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .len(len),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .o_short(o_short)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             l;
        int               cyc;
    } beat_t;

    beat_t            outq[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               short_cnt = 0;
    int               stall_err = 0;
    int               first_acc = 0;
    int               last_acc = 0;
    bit               acc_seen = 0;
    bit               rand_ready = 0;
    bit               prev_stall = 0;
    logic [WIDTH-1:0] pd = '0;
    logic             pl = 1'b0;
    logic [WIDTH-1:0] short_data = '0;
    logic             short_valid = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rand_ready) o_tready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (o_tvalid && o_tready) outq.push_back('{o_tdata, o_tlast, cyc});
            if (o_short) begin
                short_cnt++;
                short_data  = o_tdata;
                short_valid = o_tvalid;
            end
            if (prev_stall && (o_tvalid !== 1'b1 || o_tdata !== pd || o_tlast !== pl)) stall_err++;
            prev_stall = o_tvalid && !o_tready;
            pd = o_tdata;
            pl = o_tlast;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic clear_mon();
        outq.delete();
        short_cnt = 0;
        stall_err = 0;
        acc_seen  = 0;
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] d, input logic l);
        int   n = 0;
        logic acc = 1'b0;
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tlast  = l;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = i_tready;
            if (acc) begin
                if (!acc_seen) first_acc = cyc;
                acc_seen = 1;
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_beat_timeout data=%h i_tready=%b required 1", d, i_tready);
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic drain();
        rand_ready = 0;
        i_tvalid   = 1'b0;
        @(posedge clk);
        #2;
        o_tready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b required 0", o_tvalid); end
        checks++; if (o_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b required 0", o_tlast); end
        checks++; if (o_tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%h required 0", o_tdata); end
        checks++; if (o_short !== 1'b0) begin errors++; $display("FAIL reset_short got=%b required 0", o_short); end
        checks++; if (i_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got=%b required 1", i_tready); end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_strip();
        clear_mon();
        len = 4;
        for (int i = 0; i < 8; i++) send_beat(32'h10 + i, i == 7);
        drain();
        checks++; if (outq.size() != 4) begin errors++; $display("FAIL strip_count got=%0d required 4", outq.size()); end
        for (int k = 0; k < 4 && k < outq.size(); k++) begin
            checks++; if (outq[k].d !== 32'h10 + k || outq[k].l !== (k == 3)) begin
                errors++; $display("FAIL strip_beat%0d got=%h/%b required %h/%b", k, outq[k].d, outq[k].l, 32'h10 + k, k == 3);
            end
        end
        if (outq.size() > 0) begin
            checks++; if (outq[0].cyc != first_acc + 1) begin errors++; $display("FAIL strip_latency got=%0d required %0d", outq[0].cyc - first_acc, 1); end
        end
        checks++; if (last_acc - first_acc != 7) begin errors++; $display("FAIL strip_input_cycles got=%0d required 7", last_acc - first_acc); end
        checks++; if (short_cnt != 0) begin errors++; $display("FAIL strip_short got=%0d required 0", short_cnt); end
    endtask

    task automatic test_short();
        clear_mon();
        len = 4;
        for (int i = 0; i < 3; i++) send_beat(32'hA0 + i, i == 2);
        drain();
        checks++; if (outq.size() != 3) begin errors++; $display("FAIL short_count got=%0d required 3", outq.size()); end
        for (int k = 0; k < 3 && k < outq.size(); k++) begin
            checks++; if (outq[k].d !== 32'hA0 + k || outq[k].l !== (k == 2)) begin
                errors++; $display("FAIL short_beat%0d got=%h/%b required %h/%b", k, outq[k].d, outq[k].l, 32'hA0 + k, k == 2);
            end
        end
        checks++; if (short_cnt != 1) begin errors++; $display("FAIL short_pulses got=%0d required 1", short_cnt); end
        checks++; if (short_data !== 32'hA2 || short_valid !== 1'b1) begin
            errors++; $display("FAIL short_beat_data got=%h/%b required a2/1", short_data, short_valid);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        len = 4;
        for (int i = 0; i < 4; i++) send_beat(32'h40 + i, i == 3);
        for (int i = 0; i < 4; i++) send_beat(32'h50 + i, i == 3);
        drain();
        checks++; if (outq.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d required 8", outq.size()); end
        for (int k = 0; k < 8 && k < outq.size(); k++) begin
            logic [WIDTH-1:0] exp_d;
            exp_d = (k < 4) ? 32'h40 + k : 32'h50 + (k - 4);
            checks++; if (outq[k].d !== exp_d || outq[k].l !== (k == 3 || k == 7)) begin
                errors++; $display("FAIL b2b_beat%0d got=%h/%b required %h/%b", k, outq[k].d, outq[k].l, exp_d, k == 3 || k == 7);
            end
        end
        if (outq.size() == 8) begin
            checks++; if (outq[7].cyc - outq[0].cyc != 7) begin errors++; $display("FAIL b2b_gaps got=%0d required 7", outq[7].cyc - outq[0].cyc); end
        end
        checks++; if (last_acc - first_acc != 7) begin errors++; $display("FAIL b2b_input_cycles got=%0d required 7", last_acc - first_acc); end
        checks++; if (short_cnt != 0) begin errors++; $display("FAIL b2b_short got=%0d required 0", short_cnt); end
    endtask

    task automatic test_len_change();
        logic [WIDTH-1:0] exp_d [7] = '{32'h20, 32'h21, 32'h30, 32'h31, 32'h32, 32'h33, 32'h34};
        logic             exp_l [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        clear_mon();
        len = 2;
        for (int i = 0; i < 3; i++) send_beat(32'h20 + i, 1'b0);
        len = 5;
        for (int i = 3; i < 6; i++) send_beat(32'h20 + i, i == 5);
        for (int i = 0; i < 6; i++) send_beat(32'h30 + i, i == 5);
        drain();
        checks++; if (outq.size() != 7) begin errors++; $display("FAIL lenchg_count got=%0d required 7", outq.size()); end
        for (int k = 0; k < 7 && k < outq.size(); k++) begin
            checks++; if (outq[k].d !== exp_d[k] || outq[k].l !== exp_l[k]) begin
                errors++; $display("FAIL lenchg_beat%0d got=%h/%b required %h/%b", k, outq[k].d, outq[k].l, exp_d[k], exp_l[k]);
            end
        end
        checks++; if (short_cnt != 0) begin errors++; $display("FAIL lenchg_short got=%0d required 0", short_cnt); end
    endtask

    task automatic test_backpressure();
        clear_mon();
        len = 3;
        rand_ready = 1;
        for (int p = 0; p < 20; p++)
            for (int i = 0; i < 6; i++) send_beat(6 * p + i, i == 5);
        drain();
        checks++; if (outq.size() != 60) begin errors++; $display("FAIL bp_count got=%0d required 60", outq.size()); end
        for (int k = 0; k < 60 && k < outq.size(); k++) begin
            int exp_d;
            exp_d = 6 * (k / 3) + (k % 3);
            checks++; if (outq[k].d !== WIDTH'(exp_d) || outq[k].l !== (k % 3 == 2)) begin
                errors++; $display("FAIL bp_beat%0d got=%h/%b required %h/%b", k, outq[k].d, outq[k].l, exp_d, k % 3 == 2);
            end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable got=%0d changes required 0", stall_err); end
        checks++; if (short_cnt != 0) begin errors++; $display("FAIL bp_short got=%0d required 0", short_cnt); end
    endtask

    task automatic test_bypass_reset();
        clear_mon();
        len = 0;
        for (int i = 0; i < 5; i++) send_beat(32'h60 + i, i == 4);
        drain();
        checks++; if (outq.size() != 5) begin errors++; $display("FAIL bypass_count got=%0d required 5", outq.size()); end
        for (int k = 0; k < 5 && k < outq.size(); k++) begin
            checks++; if (outq[k].d !== 32'h60 + k || outq[k].l !== (k == 4)) begin
                errors++; $display("FAIL bypass_beat%0d got=%h/%b required %h/%b", k, outq[k].d, outq[k].l, 32'h60 + k, k == 4);
            end
        end
        checks++; if (short_cnt != 0) begin errors++; $display("FAIL bypass_short got=%0d required 0", short_cnt); end

        len = 3;
        send_beat(32'h70, 1'b0);
        drain();
        o_tready = 1'b0;
        send_beat(32'h71, 1'b0);
        checks++; if (o_tvalid !== 1'b1 || o_tdata !== 32'h71) begin
            errors++; $display("FAIL held_beat got=%b/%h required 1/71", o_tvalid, o_tdata);
        end
        reset_n = 1'b0;
        #1;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL async_reset_tvalid got=%b required 0", o_tvalid); end
        checks++; if (o_tdata !== '0 || o_tlast !== 1'b0) begin
            errors++; $display("FAIL async_reset_data got=%h/%b required 0/0", o_tdata, o_tlast);
        end
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        o_tready = 1'b1;
        clear_mon();
        len = 3;
        for (int i = 0; i < 4; i++) send_beat(32'h80 + i, i == 3);
        drain();
        checks++; if (outq.size() != 3) begin errors++; $display("FAIL post_reset_count got=%0d required 3", outq.size()); end
        for (int k = 0; k < 3 && k < outq.size(); k++) begin
            checks++; if (outq[k].d !== 32'h80 + k || outq[k].l !== (k == 2)) begin
                errors++; $display("FAIL post_reset_beat%0d got=%h/%b required %h/%b", k, outq[k].d, outq[k].l, 32'h80 + k, k == 2);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cycles=%0d required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_strip();
        test_short();
        test_back_to_back();
        test_len_change();
        test_backpressure();
        test_bypass_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
